// File: rtl/calc_pkg.sv
// Shared definitions for the 4-bit calculator: controller state codes,
// function codes and the result/display mux encodings used by the datapath.
package calc_pkg;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_LOAD = 4'd1,
        S_CALC = 4'd2,
        S_MUL  = 4'd3,
        S_DIV  = 4'd4,
        S_DONE = 4'd5,
        S_ERR  = 4'd6
    } state_t;

    localparam logic [2:0] F_MUL = 3'd4;
    localparam logic [2:0] F_DIV = 3'd5;

    localparam logic       SEL_H_PROD_HI = 1'b0;
    localparam logic       SEL_H_REM     = 1'b1;

    localparam logic [1:0] SEL_L_ZERO    = 2'b00;
    localparam logic [1:0] SEL_L_CALC    = 2'b01;
    localparam logic [1:0] SEL_L_PROD_LO = 2'b10;
    localparam logic [1:0] SEL_L_QUOT    = 2'b11;

    localparam logic [1:0] SEL_OUT_ZERO   = 2'b00;
    localparam logic [1:0] SEL_OUT_RESULT = 2'b01;
    localparam logic [1:0] SEL_OUT_X      = 2'b10;
    localparam logic [1:0] SEL_OUT_Y      = 2'b11;

    // Codes 0..5 select a real operation; 6 and 7 are rejected.
    function automatic logic f_valid(input logic [2:0] fc);
        return (fc <= F_DIV);
    endfunction

endpackage

// File: rtl/calc_timeout.sv
// Wait-cycle counter for the datapath handshakes. It is held at zero while
// clr is high, counts while en is high, and flags the last allowed cycle.
module calc_timeout #(
    parameter int TIMEOUT = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_r;

    // Count waiting cycles; saturate at the last value so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (en && (count_r != LAST)) begin
            count_r <= count_r + CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = en && (count_r == LAST);

endmodule

// File: rtl/calc_cu.sv
// Calculator control unit: latches the function on a go edge, loads the
// operands, dispatches to the small-calc unit, multiplier or divider, captures
// the result and selects the display source. Unit completion is bounded by a
// timeout that diverts to ERR.
module calc_cu
    import calc_pkg::*;
#(
    parameter int TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic [2:0] f,
    input  logic       Done_Calc_dp,
    input  logic       Done_DIV_dp,
    output logic       EN_F,
    output logic       EN_X,
    output logic       EN_Y,
    output logic       Go_Calc,
    output logic       Go_DIV,
    output logic [1:0] Op_Calc,
    output logic       Sel_H,
    output logic [1:0] Sel_L,
    output logic       En_Out_H,
    output logic       En_Out_L,
    output logic [1:0] Sel_out,
    output logic       done,
    output logic       err,
    output logic [3:0] cs
);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [2:0] op_r;
    logic       go_d_r;
    logic       armed_r;
    logic       start_s;
    logic       waiting_s;
    logic       expired_s;

    // armed_r keeps the first cycle after reset release quiet even if go is
    // already high, so a level held across reset never counts as an edge.
    assign start_s   = go & ~go_d_r & armed_r;
    assign waiting_s = (state_r == S_CALC) || (state_r == S_DIV);
    assign cs        = state_r;

    // Go edge detector and post-reset arming.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            go_d_r  <= 1'b0;
            armed_r <= 1'b0;
        end else begin
            go_d_r  <= go;
            armed_r <= 1'b1;
        end
    end

    // Function register, written only when a new operation is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_r <= 3'd0;
        end else if (EN_F) begin
            op_r <= f;
        end else begin
            op_r <= op_r;
        end
    end

    // Controller state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Counter is cleared outside the wait states, so it restarts on each entry.
    calc_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst_n   (reset),
        .clr     (~waiting_s),
        .en      (waiting_s),
        .expired (expired_s)
    );

    // Next-state and control-strobe decode; result enables are Mealy on done.
    always_comb begin
        state_nxt_s = state_r;
        EN_F        = 1'b0;
        EN_X        = 1'b0;
        EN_Y        = 1'b0;
        Go_Calc     = 1'b0;
        Go_DIV      = 1'b0;
        Op_Calc     = 2'b00;
        Sel_H       = SEL_H_PROD_HI;
        Sel_L       = SEL_L_ZERO;
        En_Out_H    = 1'b0;
        En_Out_L    = 1'b0;
        Sel_out     = SEL_OUT_ZERO;
        done        = 1'b0;
        err         = 1'b0;
        case (state_r)
            S_IDLE, S_DONE, S_ERR: begin
                done    = (state_r == S_DONE);
                err     = (state_r == S_ERR);
                Sel_out = (state_r == S_DONE) ? SEL_OUT_RESULT : SEL_OUT_ZERO;
                if (start_s) begin
                    EN_F        = 1'b1;
                    state_nxt_s = f_valid(f) ? S_LOAD : S_ERR;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            S_LOAD: begin
                EN_X = 1'b1;
                EN_Y = 1'b1;
                if (op_r == F_MUL) begin
                    state_nxt_s = S_MUL;
                end else if (op_r == F_DIV) begin
                    state_nxt_s = S_DIV;
                end else begin
                    state_nxt_s = S_CALC;
                end
            end
            S_CALC: begin
                Go_Calc = 1'b1;
                Op_Calc = op_r[1:0];
                Sel_L   = SEL_L_CALC;
                if (Done_Calc_dp) begin
                    En_Out_L    = 1'b1;
                    state_nxt_s = S_DONE;
                end else if (expired_s) begin
                    state_nxt_s = S_ERR;
                end else begin
                    state_nxt_s = S_CALC;
                end
            end
            S_MUL: begin
                Sel_H       = SEL_H_PROD_HI;
                Sel_L       = SEL_L_PROD_LO;
                En_Out_H    = 1'b1;
                En_Out_L    = 1'b1;
                state_nxt_s = S_DONE;
            end
            S_DIV: begin
                Go_DIV = 1'b1;
                Sel_H  = SEL_H_REM;
                Sel_L  = SEL_L_QUOT;
                if (Done_DIV_dp) begin
                    En_Out_H    = 1'b1;
                    En_Out_L    = 1'b1;
                    state_nxt_s = S_DONE;
                end else if (expired_s) begin
                    state_nxt_s = S_ERR;
                end else begin
                    state_nxt_s = S_DIV;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_calc_cu.sv
// Directed bench for calc_cu: a table of single-operation scenarios with
// hand-computed cycle numbers, plus sequences for reset, re-arming and
// asynchronous abort.
module tb_calc_cu;

    localparam int NC = 40;

    logic       clk;
    logic       reset;
    logic       go;
    logic [2:0] f;
    logic       Done_Calc_dp;
    logic       Done_DIV_dp;
    logic       EN_F, EN_X, EN_Y, Go_Calc, Go_DIV;
    logic [1:0] Op_Calc;
    logic       Sel_H;
    logic [1:0] Sel_L;
    logic       En_Out_H, En_Out_L;
    logic [1:0] Sel_out;
    logic       done, err;
    logic [3:0] cs;
    logic [19:0] outs_s;

    int tests;
    int failed;

    calc_cu #(.TIMEOUT(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .go           (go),
        .f            (f),
        .Done_Calc_dp (Done_Calc_dp),
        .Done_DIV_dp  (Done_DIV_dp),
        .EN_F         (EN_F),
        .EN_X         (EN_X),
        .EN_Y         (EN_Y),
        .Go_Calc      (Go_Calc),
        .Go_DIV       (Go_DIV),
        .Op_Calc      (Op_Calc),
        .Sel_H        (Sel_H),
        .Sel_L        (Sel_L),
        .En_Out_H     (En_Out_H),
        .En_Out_L     (En_Out_L),
        .Sel_out      (Sel_out),
        .done         (done),
        .err          (err),
        .cs           (cs)
    );

    assign outs_s = {EN_F, EN_X, EN_Y, Go_Calc, Go_DIV, Op_Calc, Sel_H, Sel_L,
                     En_Out_H, En_Out_L, Sel_out, done, err, cs};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0] f;
        int go_len;
        int kc;
        int kd;
        int x_cyc;
        int l_cyc;
        int h_cyc;
        int n_gc;
        int n_gd;
        int done_cyc;
        int err_cyc;
        int cs_end;
        int op2;
        int sel_l2;
        int sel_h2;
    } vec_t;

    // per-run observations
    int enf0, enf_cnt, x_first, x_cnt, xy_diff, l_first, l_cnt, h_first, h_cnt;
    int n_gc, n_gd, done_first, err_first, cs_last, op2, sel_l2, sel_h2;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] fv, input int go_len, input int kc, input int kd);
        enf0 = 0; enf_cnt = 0; x_first = -1; x_cnt = 0; xy_diff = 0;
        l_first = -1; l_cnt = 0; h_first = -1; h_cnt = 0; n_gc = 0; n_gd = 0;
        done_first = -1; err_first = -1; cs_last = 0; op2 = 0; sel_l2 = 0; sel_h2 = 0;
        for (int c = 0; c < NC; c++) begin
            @(posedge clk);
            #1;
            go = (c < go_len);
            f = fv;
            Done_Calc_dp = (c == kc);
            Done_DIV_dp = (c == kd);
            @(negedge clk);
            if (c == 0) enf0 = int'(EN_F);
            if (EN_F) enf_cnt++;
            if (EN_X) begin x_cnt++; if (x_first < 0) x_first = c; end
            if (EN_X != EN_Y) xy_diff++;
            if (En_Out_L) begin l_cnt++; if (l_first < 0) l_first = c; end
            if (En_Out_H) begin h_cnt++; if (h_first < 0) h_first = c; end
            if (Go_Calc) n_gc++;
            if (Go_DIV) n_gd++;
            if (c >= 1 && done && done_first < 0) done_first = c;
            if (c >= 1 && err && err_first < 0) err_first = c;
            if (c == 2) begin op2 = int'(Op_Calc); sel_l2 = int'(Sel_L); sel_h2 = int'(Sel_H); end
            cs_last = int'(cs);
        end
        go = 1'b0;
        Done_Calc_dp = 1'b0;
        Done_DIV_dp = 1'b0;
    endtask

    vec_t vecs[11];
    int   cnt;

    initial begin
        tests = 0;
        failed = 0;
        // f, go_len, kc, kd, x, l, h, ngc, ngd, done, err, cs, op2, sel_l2, sel_h2
        vecs[0]  = '{3'd7, 1, -1, -1, -1, -1, -1,  0,  0, -1,  1, 6, 0, 0, 0}; // invalid
        vecs[1]  = '{3'd4, 1, -1, -1,  1,  2,  2,  0,  0,  3, -1, 5, 0, 2, 0}; // MUL from ERR
        vecs[2]  = '{3'd5, 1, -1,  7,  1,  7,  7,  0,  6,  8, -1, 5, 0, 3, 1}; // DIV done at 7
        vecs[3]  = '{3'd2, 1, -1, -1,  1, -1, -1, 32,  0, -1, 34, 6, 2, 1, 0}; // calc timeout
        vecs[4]  = '{3'd1, 1,  2, -1,  1,  2, -1,  1,  0,  3, -1, 5, 1, 1, 0}; // done on k=2
        vecs[5]  = '{3'd3, 1, 33, -1,  1, 33, -1, 32,  0, 34, -1, 5, 3, 1, 0}; // done vs timeout
        vecs[6]  = '{3'd5, 1, -1, -1,  1, -1, -1,  0, 32, -1, 34, 6, 0, 3, 1}; // DIV timeout
        vecs[7]  = '{3'd0, 1,  6,  4,  1,  6, -1,  5,  0,  7, -1, 5, 0, 1, 0}; // stray DIV done
        vecs[8]  = '{3'd5, 1,  3,  5,  1,  5,  5,  0,  4,  6, -1, 5, 0, 3, 1}; // stray calc done
        vecs[9]  = '{3'd6, 1, -1, -1, -1, -1, -1,  0,  0, -1,  1, 6, 0, 0, 0}; // invalid
        vecs[10] = '{3'd0, 20, 3, -1,  1,  3, -1,  2,  0,  4, -1, 5, 0, 1, 0}; // held go

        // Reset with go already high: everything quiet during and after release.
        reset = 1'b0;
        go = 1'b1;
        f = 3'd4;
        Done_Calc_dp = 1'b0;
        Done_DIV_dp = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outs", int'(outs_s), 0);
        reset = 1'b1;
        #1;
        chk("release_outs", int'(outs_s), 0);
        @(negedge clk);
        chk("first_cycle_outs", int'(outs_s), 0);
        repeat (3) @(negedge clk);
        chk("held_go_no_start_cs", int'(cs), 0);
        go = 1'b0;
        @(negedge clk);

        // Table-driven single operations.
        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].f, vecs[i].go_len, vecs[i].kc, vecs[i].kd);
            chk($sformatf("v%0d_en_f_c0", i), enf0, 1);
            chk($sformatf("v%0d_en_f_cnt", i), enf_cnt, 1);
            chk($sformatf("v%0d_en_x_cyc", i), x_first, vecs[i].x_cyc);
            chk($sformatf("v%0d_en_x_cnt", i), x_cnt, (vecs[i].x_cyc >= 0) ? 1 : 0);
            chk($sformatf("v%0d_en_xy_eq", i), xy_diff, 0);
            chk($sformatf("v%0d_en_l_cyc", i), l_first, vecs[i].l_cyc);
            chk($sformatf("v%0d_en_l_cnt", i), l_cnt, (vecs[i].l_cyc >= 0) ? 1 : 0);
            chk($sformatf("v%0d_en_h_cyc", i), h_first, vecs[i].h_cyc);
            chk($sformatf("v%0d_en_h_cnt", i), h_cnt, (vecs[i].h_cyc >= 0) ? 1 : 0);
            chk($sformatf("v%0d_go_calc_n", i), n_gc, vecs[i].n_gc);
            chk($sformatf("v%0d_go_div_n", i), n_gd, vecs[i].n_gd);
            chk($sformatf("v%0d_done_cyc", i), done_first, vecs[i].done_cyc);
            chk($sformatf("v%0d_err_cyc", i), err_first, vecs[i].err_cyc);
            chk($sformatf("v%0d_cs_end", i), cs_last, vecs[i].cs_end);
            chk($sformatf("v%0d_op_calc_c2", i), op2, vecs[i].op2);
            chk($sformatf("v%0d_sel_l_c2", i), sel_l2, vecs[i].sel_l2);
            chk($sformatf("v%0d_sel_h_c2", i), sel_h2, vecs[i].sel_h2);
        end
        // After a finished run the display shows the result.
        chk("done_sel_out", int'(Sel_out), 1);

        // Re-arm: go held through a MUL, dropped one cycle, raised again.
        @(posedge clk); #1; go = 1'b1; f = 3'd4;
        @(negedge clk);
        chk("rearm_first_en_f", int'(EN_F), 1);
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (EN_F) cnt++;
        end
        chk("rearm_held_no_en_f", cnt, 0);
        chk("rearm_mul_done", int'(done), 1);
        @(posedge clk); #1; go = 1'b0;
        @(negedge clk);
        chk("rearm_low_en_f", int'(EN_F), 0);
        @(posedge clk); #1; go = 1'b1;
        @(negedge clk);
        chk("rearm_second_en_f", int'(EN_F), 1);
        @(posedge clk); #1; go = 1'b0;
        repeat (4) @(negedge clk);
        chk("rearm_second_done", int'(done), 1);

        // Asynchronous reset in the middle of a divider wait.
        @(posedge clk); #1; go = 1'b1; f = 3'd5;
        @(posedge clk); #1; go = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("abort_go_div_before", int'(Go_DIV), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_outs_zero", int'(outs_s), 0);
        chk("abort_cs_idle", int'(cs), 0);
        @(negedge clk);
        reset = 1'b1;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            Done_DIV_dp = c[0];
            Done_Calc_dp = ~c[0];
            @(negedge clk);
            if (done || (cs != 4'd0)) cnt++;
        end
        Done_DIV_dp = 1'b0;
        Done_Calc_dp = 1'b0;
        chk("abort_no_done_after", cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
